// File: rtl/fetch_predict_unit.sv
// fetch_predict_unit
//   Instruction-fetch stage: PC register, I-cache request, IF/ID latch and a
//   direct-mapped branch target buffer (BTB) with saturating counters.
//   Predicted-taken fetches redirect immediately. MEM-stage resolution trains
//   the BTB and repairs mispredictions with a redirect plus an IF/ID flush.
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   ihit_i, imemload_i      I-cache response
//   imemren_o, imemaddr_o   I-cache request (address is the current PC)
//   fetch_en_i              pipeline may advance
//   halt_i                  stop fetching; only reset leaves the halted state
//   resolve_*_i             branch/jump outcome from MEM (BTB training)
//   mispredict_i            MEM found the prediction wrong
//   redirect_pc_i           correct next PC on a mispredict
//   instr_o, pc_4_o, pred_taken_o, pred_target_o, valid_o   IF/ID latch
module fetch_predict_unit #(
  parameter logic [31:0] PC_INIT     = 32'd0,
  parameter int          AW          = 32,
  parameter int          DW          = 32,
  parameter int          BTB_ENTRIES = 16,
  parameter int          CTR_BITS    = 2,
  parameter bit          PRED_EN     = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ihit_i,
  input  logic [DW-1:0] imemload_i,
  output logic          imemren_o,
  output logic [AW-1:0] imemaddr_o,
  input  logic          fetch_en_i,
  input  logic          halt_i,
  input  logic          resolve_valid_i,
  input  logic [AW-1:0] resolve_pc_i,
  input  logic          resolve_taken_i,
  input  logic [AW-1:0] resolve_target_i,
  input  logic          mispredict_i,
  input  logic [AW-1:0] redirect_pc_i,
  output logic [DW-1:0] instr_o,
  output logic [AW-1:0] pc_4_o,
  output logic          pred_taken_o,
  output logic [AW-1:0] pred_target_o,
  output logic          valid_o
);

  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TW  = AW - IDX - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

  typedef enum logic [0:0] {ST_RUN, ST_HALTED} state_e;

  state_e              state_q;
  logic                imemren_q;
  logic [AW-1:0]       pc_q;
  logic [DW-1:0]       instr_q;
  logic [AW-1:0]       pc_4_q;
  logic                pred_taken_q;
  logic [AW-1:0]       pred_target_q;
  logic                valid_q;

  // Targets are stored word-aligned so a prediction never sets pc[1:0].
  logic                btb_vld_q [BTB_ENTRIES];
  logic [TW-1:0]       btb_tag_q [BTB_ENTRIES];
  logic [AW-3:0]       btb_tgt_q [BTB_ENTRIES];
  logic [CTR_BITS-1:0] btb_ctr_q [BTB_ENTRIES];

  logic [IDX-1:0] lk_idx, rs_idx;
  logic [TW-1:0]  lk_tag, rs_tag;
  logic [AW-1:0]  lk_target, pc_plus4, npc;
  logic           hit, rs_match, running, redirect, advance, train;

  always_comb begin
    lk_idx    = pc_q[IDX+1:2];
    lk_tag    = pc_q[AW-1:IDX+2];
    lk_target = {btb_tgt_q[lk_idx], 2'b00};
    hit       = PRED_EN && btb_vld_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag)
                && btb_ctr_q[lk_idx][CTR_BITS-1];
    pc_plus4  = pc_q + AW'(4);
    npc       = hit ? lk_target : pc_plus4;
    rs_idx    = resolve_pc_i[IDX+1:2];
    rs_tag    = resolve_pc_i[AW-1:IDX+2];
    rs_match  = btb_vld_q[rs_idx] && (btb_tag_q[rs_idx] == rs_tag);
    // A halt request freezes the whole stage in the cycle it arrives.
    running   = (state_q == ST_RUN) && !halt_i;
    redirect  = running && resolve_valid_i && mispredict_i;
    advance   = running && ihit_i && fetch_en_i;
    train     = running && resolve_valid_i;
  end

  logic unused_low_bits;
  assign unused_low_bits = ^{resolve_pc_i[1:0], resolve_target_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      imemren_q     <= 1'b1;
      pc_q          <= PC_INIT[AW-1:0];
      instr_q       <= '0;
      pc_4_q        <= '0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      valid_q       <= 1'b0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_vld_q[i] <= 1'b0;
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
        btb_ctr_q[i] <= '0;
      end
    end else begin
      if (state_q == ST_RUN && halt_i) begin
        state_q   <= ST_HALTED;
        imemren_q <= 1'b0;
      end

      if (redirect)     pc_q <= redirect_pc_i;
      else if (advance) pc_q <= npc;

      if (redirect) begin
        instr_q       <= '0;
        pc_4_q        <= '0;
        pred_taken_q  <= 1'b0;
        pred_target_q <= '0;
        valid_q       <= 1'b0;
      end else if (running && fetch_en_i) begin
        if (ihit_i) begin
          instr_q       <= imemload_i;
          pc_4_q        <= pc_plus4;
          pred_taken_q  <= hit;
          pred_target_q <= hit ? lk_target : '0;
          valid_q       <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end

      // Lookup above used pre-write contents, so same-index writes are safe.
      if (train) begin
        if (resolve_taken_i) begin
          if (rs_match) begin
            btb_tgt_q[rs_idx] <= resolve_target_i[AW-1:2];
            if (btb_ctr_q[rs_idx] != CTR_MAX)
              btb_ctr_q[rs_idx] <= btb_ctr_q[rs_idx] + CTR_BITS'(1);
          end else begin
            btb_vld_q[rs_idx] <= 1'b1;
            btb_tag_q[rs_idx] <= rs_tag;
            btb_tgt_q[rs_idx] <= resolve_target_i[AW-1:2];
            btb_ctr_q[rs_idx] <= CTR_WEAK;
          end
        end else if (rs_match && btb_ctr_q[rs_idx] != '0) begin
          btb_ctr_q[rs_idx] <= btb_ctr_q[rs_idx] - CTR_BITS'(1);
        end
      end
    end
  end

  assign imemren_o     = imemren_q;
  assign imemaddr_o    = pc_q;
  assign instr_o       = instr_q;
  assign pc_4_o        = pc_4_q;
  assign pred_taken_o  = pred_taken_q;
  assign pred_target_o = pred_target_q;
  assign valid_o       = valid_q;

endmodule

// File: tb/tb_fetch_predict_unit.sv
module tb_fetch_predict_unit;

  logic        clk = 1'b0;
  logic        rst, ihit, fetch_en, halt;
  logic [31:0] imemload;
  logic        rv, rtaken, mp;
  logic [31:0] rpc, rtgt, redir;

  logic        p_ren, p_pt, p_vld;
  logic [31:0] p_addr, p_instr, p_pc4, p_ptgt;
  logic        n_ren, n_pt, n_vld;
  logic [31:0] n_addr, n_instr, n_pc4, n_ptgt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_predict_unit #(.PRED_EN(1'b1)) u_pred (
    .clk_i(clk), .rst_i(rst), .ihit_i(ihit), .imemload_i(imemload),
    .imemren_o(p_ren), .imemaddr_o(p_addr), .fetch_en_i(fetch_en), .halt_i(halt),
    .resolve_valid_i(rv), .resolve_pc_i(rpc), .resolve_taken_i(rtaken),
    .resolve_target_i(rtgt), .mispredict_i(mp), .redirect_pc_i(redir),
    .instr_o(p_instr), .pc_4_o(p_pc4), .pred_taken_o(p_pt),
    .pred_target_o(p_ptgt), .valid_o(p_vld)
  );

  fetch_predict_unit #(.PRED_EN(1'b0)) u_nopred (
    .clk_i(clk), .rst_i(rst), .ihit_i(ihit), .imemload_i(imemload),
    .imemren_o(n_ren), .imemaddr_o(n_addr), .fetch_en_i(fetch_en), .halt_i(halt),
    .resolve_valid_i(rv), .resolve_pc_i(rpc), .resolve_taken_i(rtaken),
    .resolve_target_i(rtgt), .mispredict_i(mp), .redirect_pc_i(redir),
    .instr_o(n_instr), .pc_4_o(n_pc4), .pred_taken_o(n_pt),
    .pred_target_o(n_ptgt), .valid_o(n_vld)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic taken, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic misp, input logic [31:0] rdr);
    rv = 1'b1; rtaken = taken; rpc = pc; rtgt = tgt; mp = misp; redir = rdr;
  endtask

  task automatic no_resolve();
    rv = 1'b0; mp = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ihit = 1'b0; fetch_en = 1'b0; halt = 1'b0; imemload = '0;
    rv = 1'b0; rtaken = 1'b0; mp = 1'b0; rpc = '0; rtgt = '0; redir = '0;
    tick();
    chk("rst_addr", p_addr, 32'h0);
    chk("rst_valid", {31'd0, p_vld}, 32'd0);
    chk("rst_instr", p_instr, 32'h0);
    chk("rst_ren", {31'd0, p_ren}, 32'd1);

    // sequential fetch
    rst = 1'b0; ihit = 1'b1; fetch_en = 1'b1; imemload = 32'hA;
    chk("seq_addr0", p_addr, 32'h0);
    tick();
    chk("seq_addr1", p_addr, 32'h4);
    chk("seq_instrA", p_instr, 32'hA);
    chk("seq_pc4_A", p_pc4, 32'h4);
    chk("seq_validA", {31'd0, p_vld}, 32'd1);
    imemload = 32'hB;
    tick();
    chk("seq_addr2", p_addr, 32'h8);
    chk("seq_instrB", p_instr, 32'hB);
    chk("seq_pc4_B", p_pc4, 32'h8);
    imemload = 32'hC;
    tick();
    chk("seq_addr3", p_addr, 32'hC);
    chk("seq_instrC", p_instr, 32'hC);
    chk("seq_pc4_C", p_pc4, 32'hC);

    // train taken 0x10 -> 0x40 while fetch moves 0xC -> 0x10
    imemload = 32'hD;
    resolve(1'b1, 32'h10, 32'h40, 1'b0, 32'h0);
    tick();
    no_resolve();
    imemload = 32'hE;
    chk("btb_at_0x10", p_addr, 32'h10);
    tick();
    chk("btb_pred_addr", p_addr, 32'h40);
    chk("btb_pred_taken", {31'd0, p_pt}, 32'd1);
    chk("btb_pred_tgt", p_ptgt, 32'h40);
    chk("btb_pc4", p_pc4, 32'h14);
    chk("nopred_addr", n_addr, 32'h14);
    chk("nopred_taken", {31'd0, n_pt}, 32'd0);
    chk("nopred_tgt", n_ptgt, 32'h0);

    // not-taken resolve with redirect back to 0x10: ctr 10 -> 01
    ihit = 1'b0;
    resolve(1'b0, 32'h10, 32'h0, 1'b1, 32'h10);
    tick();
    chk("redir_addr", p_addr, 32'h10);
    chk("redir_flush", {31'd0, p_vld}, 32'd0);
    no_resolve();
    ihit = 1'b1; imemload = 32'h11;
    tick();
    chk("weakNT_addr", p_addr, 32'h14);
    chk("weakNT_taken", {31'd0, p_pt}, 32'd0);
    chk("weakNT_instr", p_instr, 32'h11);
    // two more not-taken: 01 -> 00 -> 00 (saturate low)
    ihit = 1'b0;
    resolve(1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    chk("bubble_valid", {31'd0, p_vld}, 32'd0);
    chk("bubble_hold_addr", p_addr, 32'h14);
    // taken on a still-valid entry increments 00 -> 01 (no allocation)
    resolve(1'b1, 32'h10, 32'h40, 1'b1, 32'h10);
    tick();
    no_resolve();
    ihit = 1'b1;
    tick();
    chk("stays_valid_addr", p_addr, 32'h14);
    // 01 -> 10 with a new target
    ihit = 1'b0;
    resolve(1'b1, 32'h10, 32'h44, 1'b1, 32'h10);
    tick();
    no_resolve();
    ihit = 1'b1;
    tick();
    chk("retgt_addr", p_addr, 32'h44);
    chk("retgt_ptgt", p_ptgt, 32'h44);
    chk("nopred_addr2", n_addr, 32'h14);
    // 10 -> 11 -> 11 (saturate high), then one not-taken -> 10 still predicts
    ihit = 1'b0;
    resolve(1'b1, 32'h10, 32'h44, 1'b0, 32'h0);
    tick();
    tick();
    resolve(1'b0, 32'h10, 32'h0, 1'b1, 32'h10);
    tick();
    no_resolve();
    ihit = 1'b1; imemload = 32'h22;
    tick();
    chk("sat_addr", p_addr, 32'h44);
    chk("sat_taken", {31'd0, p_pt}, 32'd1);

    // fetch_en=0 holds everything
    fetch_en = 1'b0; imemload = 32'h33;
    tick();
    chk("hold_addr", p_addr, 32'h44);
    chk("hold_instr", p_instr, 32'h22);
    chk("hold_valid", {31'd0, p_vld}, 32'd1);

    // mispredict while fetch_en=0 and ihit=1; also allocates 0x80 -> 0x100
    resolve(1'b1, 32'h80, 32'h100, 1'b1, 32'h80);
    tick();
    chk("misp_addr", p_addr, 32'h80);
    chk("misp_valid", {31'd0, p_vld}, 32'd0);
    chk("misp_nopred_addr", n_addr, 32'h80);
    no_resolve();
    fetch_en = 1'b1;
    tick();
    chk("alloc_addr", p_addr, 32'h100);
    chk("alloc_ptgt", p_ptgt, 32'h100);
    chk("alloc_nopred_addr", n_addr, 32'h84);

    // pc+4 wraps
    ihit = 1'b0;
    resolve(1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'hFFFF_FFFC);
    tick();
    no_resolve();
    ihit = 1'b1; imemload = 32'h55;
    tick();
    chk("wrap_addr", p_addr, 32'h0);
    chk("wrap_pc4", p_pc4, 32'h0);

    // halt, then everything frozen
    ihit = 1'b0; fetch_en = 1'b0; halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_ren", {31'd0, p_ren}, 32'd0);
    ihit = 1'b1; fetch_en = 1'b1; imemload = 32'h66;
    resolve(1'b1, 32'h0, 32'h300, 1'b1, 32'h200);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halted_addr", p_addr, 32'h0);
      chk("halted_instr", p_instr, 32'h55);
      chk("halted_ren", {31'd0, p_ren}, 32'd0);
    end

    // reset clears state and BTB
    no_resolve();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_addr", p_addr, 32'h0);
    chk("rst2_valid", {31'd0, p_vld}, 32'd0);
    chk("rst2_ren", {31'd0, p_ren}, 32'd1);
    ihit = 1'b0;
    resolve(1'b0, 32'h10, 32'h0, 1'b1, 32'h10);
    tick();
    no_resolve();
    ihit = 1'b1;
    tick();
    chk("cleared_addr", p_addr, 32'h14);
    chk("cleared_taken", {31'd0, p_pt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
